wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter sharing the regfile's single unlock-write port between the functional-unit write-back requesters (ALU, MUL, DIV, LSU). It selects one valid request per cycle in round-robin order and registers the selected address and data onto the regfile's `wr_unlock_*` inputs. Committing a result and releasing the destination register's lock therefore happen in one registered write. The block also exposes a saturating contention counter for performance analysis.

## Interface
- `NUM_REQ`, default 4: number of write-back requesters (≥2).
- `NUM_REGS`, default `maverickOne_pkg::NUM_REGS`: register count; `AW = $clog2(NUM_REGS)`.
- `XLEN`, default `maverickOne_pkg::XLEN`: data width.
- `CNT_W`, default 32: contention counter width.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `arst_i` in 1: asynchronous reset, active-high.
- `req_valid_i` in `[NUM_REQ]`: requester k holds a result.
- `req_addr_i` in `[NUM_REQ][AW]`: destination register per requester.
- `req_data_i` in `[NUM_REQ][XLEN]`: result data per requester.
- `req_ready_o` out `[NUM_REQ]`: grant; a transfer occurs when `valid & ready` in the same cycle.
- `wr_unlock_en_o` out 1: to regfile `wr_unlock_en_i`.
- `wr_unlock_addr_o` out AW: to regfile `wr_unlock_addr_i`.
- `wr_unlock_data_o` out XLEN: to regfile `wr_unlock_data_i`.
- `conflict_cnt_o` out `CNT_W`: count of cycles with ≥2 requests valid.

## Operation
- State:
  - round-robin pointer `ptr` (log2 NUM_REQ bits);
  - output register (en, addr, data);
  - contention counter.
- Arbitration:
  - Combinational; the winner is the first valid requester scanning `ptr, ptr+1, …` modulo NUM_REQ.
  - `req_ready_o` is one-hot at the winner, or all-zero when no request is valid.
  - Ready depends only on `req_valid_i` and state, never on addr or data.
- Pointer update: on a transfer by requester k, `ptr <= (k+1) mod NUM_REQ`. No transfer leaves `ptr` unchanged.
- Output register:
  - On a transfer: `en <= (addr != 0)`, `addr <= req_addr_i[k]`, `data <= req_data_i[k]`.
  - With no transfer: `en <= 0`, and addr/data hold their last values.
- x0 requests are accepted and consume the grant (the pointer advances) but never assert `wr_unlock_en_o`.
- The regfile port always accepts, so there is no back-pressure and the output register never stalls.
- Counter: increments when `popcount(req_valid_i) ≥ 2` and saturates at all-ones.
- Requesters must hold valid/addr/data stable until granted. Dropping valid before a grant is permitted (no transfer occurs).
- Same-address, same-cycle lock and unlock at the regfile is resolved by the regfile (lock wins). This block takes no action.

## Timing
- Latency: a transfer in cycle t produces `wr_unlock_*` valid in cycle t+1, for exactly one cycle. The regfile commits at the edge ending t+1.
- Throughput: one write-back per cycle. A requester holding valid continuously with N others competing is granted at least once every NUM_REQ cycles.
- Reset (asynchronous, immediate on `arst_i` high):
  - `ptr = 0`;
  - `wr_unlock_en_o = 0`, `wr_unlock_addr_o = 0`, `wr_unlock_data_o = 0`;
  - `conflict_cnt_o = 0`;
  - `req_ready_o` forced to all-zero while `arst_i` is high.
- Reset mid-operation: an in-flight output-register write is discarded, and no transfer is recorded in a cycle where `arst_i` is high. After deassertion, the first grant goes to the lowest-index valid requester.
- Wrap-around: a grant to requester NUM_REQ-1 sets `ptr = 0`.

## Structure
- `maverickOne_pkg` additions:
  - `NUM_WB_PORTS` (=4);
  - `wb_req_t` struct {`addr [AW]`, `data [XLEN]`} for requester buses.
  - `NUM_REGS` and `XLEN` already reside in the package.
- Sub-module `wb_rr_arbiter`: parameterised combinational rotating-priority arbiter. Inputs are `req[NUM_REQ]` and `ptr`; outputs are one-hot `gnt` and `gnt_idx`. Reusable for other shared ports.
- The top level holds `ptr`, the output register and the counter.

## Test plan
- Single requester: req2 valid, addr 5, data 0xDEADBEEF, with the others idle. Required: `ready[2]=1` in the same cycle; the next cycle shows `wr_unlock_en_o=1`, addr 5, data 0xDEADBEEF; `ptr=3`; counter stays 0.
- All four requesters valid continuously for 8 cycles, starting from reset. Required: grants in order 0,1,2,3,0,1,2,3; one write per cycle; `conflict_cnt_o=8`.
- x0 request: req1 addr 0 valid. Required: `ready[1]=1`, `wr_unlock_en_o=0` the next cycle, and the pointer advances to 2.
- Wrap-around: `ptr=3` with req0 and req3 valid. Required: grant to 3, then to 0 next, and `ptr=1` afterwards.
- Reset mid-operation: assert `arst_i` in the cycle after a grant. Required: `wr_unlock_en_o` drops to 0 immediately; `ready=0` while reset is held; `ptr=0` and counter 0 after release.
- Integration: connect to the regfile and run random requests (with the regfile lock port driven randomly) for 10⁵ cycles. Required: regfile contents and locks match a reference model; no requester is waiting more than NUM_REQ cycles once valid.

Source files
------------

// File: rtl/maverickOne_pkg.sv
// Shared core-wide constants and the write-back requester bus type.
package maverickOne_pkg;

   localparam int NUM_REGS     = 32;
   localparam int XLEN         = 32;
   localparam int NUM_WB_PORTS = 4;
   localparam int REG_AW       = $clog2(NUM_REGS);

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first asserted request at or after ptr wins.
module wb_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PW-1:0]      gnt_idx
);

   // Scan ptr, ptr+1, ... modulo NUM_REQ; the found flag freezes the first hit.
   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin share of the regfile unlock-write port, with a
// registered write and a saturating contention counter.
module wb_arbiter #(
   parameter int NUM_REQ  = maverickOne_pkg::NUM_WB_PORTS,
   parameter int NUM_REGS = maverickOne_pkg::NUM_REGS,
   parameter int XLEN     = maverickOne_pkg::XLEN,
   parameter int CNT_W    = 32,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic                           clk_i,
   input  logic                           arst_i,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ-1:0][AW-1:0]     req_addr_i,
   input  logic [NUM_REQ-1:0][XLEN-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic                           wr_unlock_en_o,
   output logic [AW-1:0]                  wr_unlock_addr_o,
   output logic [XLEN-1:0]                wr_unlock_data_o,
   output logic [CNT_W-1:0]               conflict_cnt_o
);

   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0]      ptr;
   logic [PW-1:0]      gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic               transfer;
   logic               multi_req;

   wb_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr_arbiter (
      .req     (req_valid_i),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Grants are withheld during reset so no requester believes it transferred.
   assign req_ready_o = arst_i ? '0 : gnt;
   assign transfer    = |gnt;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_req   = |(req_valid_i & (req_valid_i - NUM_REQ'(1)));

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         ptr              <= '0;
         wr_unlock_en_o   <= 1'b0;
         wr_unlock_addr_o <= '0;
         wr_unlock_data_o <= '0;
         conflict_cnt_o   <= '0;
      end else begin
         wr_unlock_en_o <= 1'b0;
         if (transfer) begin
            // x0 results still consume the grant but must not touch the regfile.
            wr_unlock_en_o   <= (req_addr_i[gnt_idx] != '0);
            wr_unlock_addr_o <= req_addr_i[gnt_idx];
            wr_unlock_data_o <= req_data_i[gnt_idx];
            ptr              <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
         end
         if (multi_req && (conflict_cnt_o != '1)) begin
            conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized requesters
// compared against a queue-free round-robin reference model.
module tb_wb_arbiter;

   localparam int N  = 4;
   localparam int AW = 5;
   localparam int XW = 32;
   localparam int CW = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N-1:0]            req_valid;
   logic [N-1:0][AW-1:0]    req_addr;
   logic [N-1:0][XW-1:0]    req_data;
   logic [N-1:0]            req_ready;
   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic [XW-1:0]           wr_data;
   logic [CW-1:0]           conflict_cnt;

   int errors = 0;
   int checks = 0;

   int            m_ptr;
   logic          m_en;
   logic [AW-1:0] m_addr;
   logic [XW-1:0] m_data;
   int            m_cnt;
   int            wait_cnt [N];

   always #5 clk = ~clk;

   wb_arbiter #(.NUM_REQ(N), .NUM_REGS(32), .XLEN(XW), .CNT_W(CW)) dut (
      .clk_i            (clk),
      .arst_i           (rst),
      .req_valid_i      (req_valid),
      .req_addr_i       (req_addr),
      .req_data_i       (req_data),
      .req_ready_o      (req_ready),
      .wr_unlock_en_o   (wr_en),
      .wr_unlock_addr_o (wr_addr),
      .wr_unlock_data_o (wr_data),
      .conflict_cnt_o   (conflict_cnt)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_ptr  = 0;
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_cnt  = 0;
      for (int k = 0; k < N; k++) wait_cnt[k] = 0;
   endtask

   // One bus cycle: present inputs, check the grant, clock, then check the write port.
   task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                                input logic [N-1:0][XW-1:0] d, output int w);
      logic [N-1:0] exp_ready;
      int           nv;
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      #1;
      w = -1;
      for (int i = 0; i < N; i++) begin
         if (w < 0 && v[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      end
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      checkOutput("ready", 64'(req_ready), 64'(exp_ready));
      nv = $countones(v);
      @(posedge clk);
      #1;
      if (w >= 0) begin
         m_en   = (a[w] != '0);
         m_addr = a[w];
         m_data = d[w];
         m_ptr  = (w + 1) % N;
      end else begin
         m_en = 1'b0;
      end
      if (nv >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
      for (int k = 0; k < N; k++) begin
         if (v[k] && k != w) wait_cnt[k]++;
         else wait_cnt[k] = 0;
         checkOutput("starve", 64'(wait_cnt[k] >= N), 64'(0));
      end
      checkOutput("wr_en",   64'(wr_en),        64'(m_en));
      checkOutput("wr_addr", 64'(wr_addr),      64'(m_addr));
      checkOutput("wr_data", 64'(wr_data),      64'(m_data));
      checkOutput("cnt",     64'(conflict_cnt), 64'(m_cnt));
   endtask

   // Asserts reset between edges with all requesters valid; everything must clear at once.
   task automatic resetPulse();
      rst       = 1'b1;
      req_valid = '1;
      #1;
      checkOutput("rst_en",    64'(wr_en),        64'(0));
      checkOutput("rst_addr",  64'(wr_addr),      64'(0));
      checkOutput("rst_data",  64'(wr_data),      64'(0));
      checkOutput("rst_cnt",   64'(conflict_cnt), 64'(0));
      checkOutput("rst_ready", 64'(req_ready),    64'(0));
      @(posedge clk);
      #1;
      checkOutput("rst_ready_hold", 64'(req_ready),    64'(0));
      checkOutput("rst_cnt_hold",   64'(conflict_cnt), 64'(0));
      rst       = 1'b0;
      req_valid = '0;
      modelReset();
   endtask

   initial begin
      logic [N-1:0][AW-1:0] a;
      logic [N-1:0][XW-1:0] d;
      logic [N-1:0]         pend;
      int                   w;

      rst       = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      a         = '0;
      d         = '0;
      #12;
      resetPulse();

      // Single requester 2 with the others idle.
      a[2] = 5'd5;
      d[2] = 32'hDEADBEEF;
      applyStimulus(4'b0100, a, d, w);
      checkOutput("single_en",   64'(wr_en),        64'(1));
      checkOutput("single_addr", 64'(wr_addr),      64'(5));
      checkOutput("single_data", 64'(wr_data),      64'hDEADBEEF);
      checkOutput("single_cnt",  64'(conflict_cnt), 64'(0));

      // Wrap-around from ptr=3 with requesters 0 and 3 competing.
      a[0] = 5'd7;  d[0] = 32'h00000700;
      a[3] = 5'd9;  d[3] = 32'h00000900;
      applyStimulus(4'b1001, a, d, w);
      checkOutput("wrap_addr3", 64'(wr_addr), 64'(9));
      applyStimulus(4'b0001, a, d, w);
      checkOutput("wrap_addr0", 64'(wr_addr), 64'(7));

      // x0 request from requester 1 consumes the grant silently, pointer moves to 2.
      a[1] = 5'd0;  d[1] = 32'h12345678;
      applyStimulus(4'b0010, a, d, w);
      checkOutput("x0_en", 64'(wr_en), 64'(0));
      a[1] = 5'd3;
      a[2] = 5'd4;  d[2] = 32'h00000400;
      applyStimulus(4'b0110, a, d, w);
      checkOutput("x0_ptr2", 64'(wr_addr), 64'(4));

      // All four valid for eight cycles straight out of reset.
      resetPulse();
      for (int k = 0; k < N; k++) begin
         a[k] = AW'(k + 10);
         d[k] = 32'hA000 + 32'(k);
      end
      for (int c = 0; c < 8; c++) begin
         applyStimulus(4'b1111, a, d, w);
         checkOutput("rr_order", 64'(wr_addr), 64'(10 + (c % N)));
      end
      checkOutput("rr_cnt8", 64'(conflict_cnt), 64'(8));

      // Reset in the cycle after a grant; afterwards the lowest valid index wins.
      applyStimulus(4'b1111, a, d, w);
      resetPulse();
      applyStimulus(4'b1001, a, d, w);
      checkOutput("post_rst_grant", 64'(wr_addr), 64'(10));

      // Randomized requesters holding their request until granted, with occasional drops.
      pend = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 2) != 0) begin
               pend[k] = 1'b1;
               a[k]    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
               d[k]    = $urandom;
            end else if (pend[k] && $urandom_range(0, 29) == 0) begin
               pend[k] = 1'b0;
            end
         end
         applyStimulus(pend, a, d, w);
         if (w >= 0) pend[w] = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
